// File: rtl/add_pkg.sv
// Shared constants and types for the add_rsp adder / response buffer.
package add_pkg;

    localparam int ADD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_e;

    typedef logic [ADD_WIDTH:0] result_t;

endpackage

// File: rtl/add_rsp_fifo.sv
// Result buffer for add_rsp: storage, wrap-around pointers, occupancy and a
// registered head/valid pair so the consumer side never sees input logic.
module add_rsp_fifo
    import add_pkg::*;
#(
    parameter int DATA_W = ADD_WIDTH + 1,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       head,
    output logic                    nonempty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] head_r;
    logic              nonempty_r;

    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [PTR_W-1:0]  rd_nxt_s;
    logic [DATA_W-1:0] head_nxt_s;

    // Never push into a full buffer or pop an empty one, whatever the caller does.
    assign push_s = push && (count_r != CNT_DEPTH);
    assign pop_s  = pop && nonempty_r;

    // Next occupancy, read pointer and the entry that will sit at the head.
    always_comb begin
        count_nxt_s = count_r;
        rd_nxt_s    = rd_ptr_r;
        head_nxt_s  = '0;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        // The incoming word becomes head when no older entry survives this edge.
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if ((count_r == '0) || (pop_s && (count_r == CNT_ONE))) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pointer, occupancy and registered head/valid update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            head_r     <= '0;
            nonempty_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_nxt_s;
            count_r    <= count_nxt_s;
            head_r     <= head_nxt_s;
            nonempty_r <= (count_nxt_s != '0);
        end
    end

    // Storage write; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign head     = head_r;
    assign nonempty = nonempty_r;
    assign count    = count_r;

endmodule

// File: rtl/add_rsp.sv
// Unsigned adder with a DEPTH-entry in-order result buffer and a completed-
// result counter that is only built when ADD_RSP_CNT_EN is defined.
module add_rsp
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy,
    output logic [7:0]       txn_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] OCC_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] OCC_LAST = CNT_W'(DEPTH - 1);

    state_e           state_r;
    logic [WIDTH:0]   add_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_valid_s;
    logic [WIDTH:0]   fifo_head_s;
    logic [CNT_W-1:0] occ_s;

    // Operands are zero-extended so the carry lands in the top bit.
    assign add_s      = {1'b0, a} + {1'b0, b};
    assign in_ready_s = !rst && (state_r != FULL);
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = fifo_valid_s && out_ready;

    add_rsp_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .wdata    (add_s),
        .head     (fifo_head_s),
        .nonempty (fifo_valid_s),
        .count    (occ_s)
    );

    // Occupancy state machine; FULL is what withholds in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (push_s) state_r <= ACTIVE;
                    else        state_r <= IDLE;
                end
                ACTIVE: begin
                    if (push_s && !pop_s && (occ_s == OCC_LAST))     state_r <= FULL;
                    else if (pop_s && !push_s && (occ_s == OCC_ONE)) state_r <= IDLE;
                    else                                             state_r <= ACTIVE;
                end
                FULL: begin
                    if (pop_s) state_r <= ACTIVE;
                    else       state_r <= FULL;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef ADD_RSP_CNT_EN
    logic [7:0] txn_cnt_r;

    // Completed-result counter; wraps 255 -> 0 by its natural width.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_r <= 8'd0;
        end else if (pop_s) begin
            txn_cnt_r <= txn_cnt_r + 8'd1;
        end else begin
            txn_cnt_r <= txn_cnt_r;
        end
    end

    assign txn_cnt = txn_cnt_r;
`else
    assign txn_cnt = 8'd0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = fifo_valid_s;
    assign busy      = fifo_valid_s;
    assign sum       = fifo_head_s;

endmodule

// File: tb/tb_add_rsp.sv
// Directed bench for add_rsp: hand-checked vectors plus a per-cycle queue model.
module tb_add_rsp;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
`ifdef ADD_RSP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;
    logic [7:0]       txn_cnt;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         q[$];
    logic [7:0] m_cnt = 8'd0;

    add_rsp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance the reference queue from the pre-edge inputs, then compare.
    task automatic cycle();
        bit m_push;
        bit m_pop;
        int tmp;
        m_pop  = !rst && (q.size() > 0) && out_ready;
        m_push = !rst && in_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 8'd0;
        end else begin
            if (m_pop) begin
                tmp   = q.pop_front();
                m_cnt = m_cnt + 8'd1;
            end
            if (m_push) q.push_back(int'(a) + int'(b));
        end
        #1;
        chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_sum", 32'(sum), (q.size() > 0) ? q[0] : 32'd0);
        chk("m_busy", 32'(busy), 32'(q.size() > 0));
        chk("m_in_ready", 32'(in_ready), 32'(!rst && (q.size() < DEPTH)));
        chk("m_txn_cnt", 32'(txn_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 4'd0; b = 4'd0;

        // reset
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_txn", 32'(txn_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // 4+4 with consumer ready: one-cycle latency, then popped
        a = 4'd4; b = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk("b_valid", 32'(out_valid), 32'd1);
        chk("b_sum8", 32'(sum), 32'd8);
        in_valid = 1'b0;
        cycle();
        chk("b_txn1", 32'(txn_cnt), CNT_EN ? 32'd1 : 32'd0);
        chk("b_empty", 32'(out_valid), 32'd0);

        // full-width carry and ordering
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd15; b = 4'd15;
        cycle();
        a = 4'd3; b = 4'd7;
        cycle();
        in_valid = 1'b0;
        chk("c_sum30", 32'(sum), 32'd30);
        chk("c_bit4", 32'(sum[4]), 32'd1);
        chk("c_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("c_sum10", 32'(sum), 32'd10);
        cycle();
        chk("c_drain", 32'(out_valid), 32'd0);

        // backpressure: third pair waits until space frees
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd1; b = 4'd1;
        cycle();
        a = 4'd2; b = 4'd2;
        cycle();
        chk("d_ready0", 32'(in_ready), 32'd0);
        a = 4'd3; b = 4'd3;
        cycle();
        chk("d_hold2", 32'(sum), 32'd2);
        chk("d_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("d_sum4", 32'(sum), 32'd4);
        cycle();
        chk("d_sum6", 32'(sum), 32'd6);
        in_valid = 1'b0;
        cycle();
        chk("d_drain", 32'(out_valid), 32'd0);

        // simultaneous push/pop at occupancy 1 (= DEPTH-1)
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd0;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = i[3:0]; b = 4'd1;
            cycle();
            chk("e_sum", 32'(sum), 32'(i + 1));
            chk("e_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk("e_drain", 32'(out_valid), 32'd0);

        // reset while full discards everything
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd9; b = 4'd9;
        cycle();
        a = 4'd1; b = 4'd2;
        cycle();
        in_valid = 1'b0;
        chk("f_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        chk("f_rst_valid", 32'(out_valid), 32'd0);
        chk("f_rst_sum", 32'(sum), 32'd0);
        chk("f_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("f_rel_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        cycle();
        chk("f_no_stale", 32'(out_valid), 32'd0);
        chk("f_txn0", 32'(txn_cnt), 32'd0);

        // 256 pops: counter wraps (or stays tied off)
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = i[3:0]; b = i[7:4];
            cycle();
        end
        chk("g_txn255", 32'(txn_cnt), CNT_EN ? 32'd255 : 32'd0);
        in_valid = 1'b0;
        cycle();
        chk("g_txn_wrap", 32'(txn_cnt), 32'd0);
        chk("g_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
